uart_tx_serializer: RTL
=======================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter OVERSAMPLE, default 16, number of baud_tick pulses per serial bit (2..16).
REQ-002 clock  input  1  system clock; all logic on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 baud_tick  input  1  one-clock enable pulse at OVERSAMPLE x baud rate.
REQ-005 fifo_empty  input  1  TX FIFO empty flag.
REQ-006 fifo_read_n  output  1  active-low FIFO pop, exactly one clock wide per byte.
REQ-007 fifo_data  input  8  FIFO output byte, registered inside the FIFO.
REQ-008 bit8  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-009 parity_en  input  1  1 = append parity bit.
REQ-010 odd_n_even  input  1  1 = odd parity, 0 = even parity.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 tx_busy  output  1  high from the pop until the last stop-bit tick.
REQ-013 tx_done  output  1  one-clock pulse when a frame's stop bit completes.

Function
REQ-014 FSM states: IDLE, POP, WAIT1, WAIT2, START, DATA, PARITY, STOP.
REQ-015 IDLE -> POP when fifo_empty=0; POP drives fifo_read_n=0 for that single clock.
REQ-016 POP -> WAIT1 -> WAIT2 unconditionally; at the WAIT2 clock edge fifo_data is captured into an 8-bit shift register (byte valid 2 edges after the pop).
REQ-017 bit8, parity_en and odd_n_even are sampled at the same edge as fifo_data and held for the frame.
REQ-018 WAIT2 -> START on the next edge; START drives tx=0 and clears the tick counter.
REQ-019 Each bit state lasts exactly OVERSAMPLE baud_tick pulses; the counter advances only on baud_tick=1.
REQ-020 DATA sends LSB first; 8 bits if bit8=1, else bits [6:0] only.
REQ-021 PARITY present only if parity_en=1; bit = XOR of sent data bits, inverted when odd_n_even=1.
REQ-022 STOP drives tx=1 for one bit time; at its last tick tx_done pulses and FSM goes to IDLE.
REQ-023 Back-to-back: if fifo_empty=0 in the IDLE clock after tx_done, POP follows immediately (no extra idle bit).
REQ-024 fifo_read_n never goes low while fifo_empty=1 or while state is not POP (no underflow, no double pop).
REQ-025 fifo_empty changes during a frame do not affect the frame in progress.
REQ-026 tx registered (glitch-free); tx=1 in IDLE, POP, WAIT1, WAIT2, STOP.
REQ-027 tx_busy=1 in every state except IDLE.

Reset
REQ-028 On reset_n=0: state=IDLE, tx=1, fifo_read_n=1, tx_busy=0, tx_done=0, counters and shift register 0.
REQ-029 Reset asserted mid-frame aborts it immediately; tx returns high with no partial stop bit; the aborted byte is lost.
REQ-030 After reset release the first pop occurs no earlier than the second clock edge.

Configuration
REQ-031 Macro UART_TX_PARITY_EN defined: parity logic and PARITY state compiled in per REQ-021.
REQ-032 Macro UART_TX_PARITY_EN undefined: parity_en and odd_n_even ignored, PARITY state absent, frames never carry a parity bit.

Verification
REQ-033 OVERSAMPLE=16, byte 0x55, bit8=1, parity_en=0 -> tx: 0, 1,0,1,0,1,0,1,0, 1; each bit 16 ticks; one tx_done pulse.
REQ-034 Byte 0xA3, bit8=0, parity_en=1, odd_n_even=1 (macro on) -> data 1,1,0,0,0,1,0; parity 0; stop 1.
REQ-035 Three bytes queued (0x01, 0x02, 0x03) -> exactly three single-clock fifo_read_n pulses; frames contiguous; no idle bit between them.
REQ-036 fifo_empty=1 for 1000 clocks -> fifo_read_n stays 1, tx stays 1, tx_busy stays 0.
REQ-037 reset_n pulsed low during DATA bit 3 -> tx=1 within the same cycle; state IDLE; next queued byte transmitted complete.
REQ-038 Macro off, parity_en=1, byte 0xFF -> 10-bit frame, no parity bit.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Pops bytes from a TX FIFO and sends them as asynchronous serial frames:
//   start bit, 7 or 8 data bits LSB first, optional parity bit, one stop bit.
//   Every bit lasts OVERSAMPLE baud_tick pulses.
//
//   Build option: define UART_TX_PARITY_EN to compile in the parity bit.
//   When UART_TX_PARITY_EN is undefined, parity_en and odd_n_even are ignored
//   and no frame ever carries a parity bit.
//
// Ports
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   baud_tick    one-clock enable at OVERSAMPLE x baud rate
//   fifo_empty   TX FIFO empty flag
//   fifo_read_n  active-low FIFO pop, one clock wide per byte
//   fifo_data    FIFO output byte (registered inside the FIFO)
//   bit8         1 = 8 data bits, 0 = 7 data bits
//   parity_en    1 = append parity bit (UART_TX_PARITY_EN builds only)
//   odd_n_even   1 = odd parity, 0 = even parity
//   tx           serial line, idle high, registered
//   tx_busy      high in every state except IDLE
//   tx_done      one-clock pulse on the last tick of the stop bit
`timescale 1ns/1ps

module uart_tx_serializer #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       baud_tick,
    input  logic       fifo_empty,
    output logic       fifo_read_n,
    input  logic [7:0] fifo_data,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned          CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT1,
        WAIT2,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             bit8_q,    bit8_d;
    logic             tx_q,      tx_d;
    logic             bit_end;
    logic [2:0]       last_idx;

`ifdef UART_TX_PARITY_EN
    logic             parity_en_q,  parity_en_d;
    logic             parity_bit_q, parity_bit_d;
`else
    logic             unused_parity_cfg;
    assign unused_parity_cfg = parity_en ^ odd_n_even;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            bit8_q       <= 1'b0;
            tx_q         <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_en_q  <= 1'b0;
            parity_bit_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            bit8_q       <= bit8_d;
            tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_en_q  <= parity_en_d;
            parity_bit_q <= parity_bit_d;
`endif
        end
    end

    assign bit_end  = baud_tick && (cnt_q == CNT_LAST);
    assign last_idx = bit8_q ? 3'd7 : 3'd6;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        bit8_d       = bit8_q;
        tx_d         = tx_q;
        tx_done      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_en_d  = parity_en_q;
        parity_bit_d = parity_bit_q;
`endif

        // Bit-time counter runs only in the four line states and wraps on the
        // last tick so every bit state starts from zero.
        if (state_q inside {START, DATA, STOP}
`ifdef UART_TX_PARITY_EN
            || state_q == PARITY
`endif
           ) begin
            if (baud_tick) begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            end
        end

        // tx is registered, so each branch sets the value the line takes in
        // the state being entered.
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                tx_d    = 1'b1;
                state_d = WAIT1;
            end
            WAIT1: begin
                tx_d    = 1'b1;
                state_d = WAIT2;
            end
            WAIT2: begin
                // FIFO output is valid two edges after the pop; frame
                // configuration is latched with it and held for the frame.
                shift_d      = fifo_data;
                bit8_d       = bit8;
`ifdef UART_TX_PARITY_EN
                parity_en_d  = parity_en;
                parity_bit_d = (^(fifo_data & {bit8, 7'h7F})) ^ odd_n_even;
`endif
                cnt_d        = '0;
                bit_idx_d    = '0;
                tx_d         = 1'b0;
                state_d      = START;
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == last_idx) begin
`ifdef UART_TX_PARITY_EN
                        if (parity_en_q) begin
                            tx_d    = parity_bit_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    tx_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_read_n = (state_q != POP);
    assign tx_busy     = (state_q != IDLE);
    assign tx          = tx_q;

endmodule
